// File: rtl/jtag_vpi_pkg.sv
// Shared definitions for the JTAG bit-bang sequencer.
//  - cmd_op_e     : host command opcodes
//  - seq_state_e  : sequencer FSM states (exposed on dbg_state)
//  - RESET_TMS_CYCLES : tms=1 slots issued by a TAP reset command
//  - op_shifts_data() : true for the ops that drive tdi and capture tdo
package jtag_vpi_pkg;

  typedef enum logic [1:0] {
    CMD_RESET         = 2'd0,
    CMD_TMS_SEQ       = 2'd1,
    CMD_SCAN          = 2'd2,
    CMD_SCAN_FLIP_TMS = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int RESET_TMS_CYCLES = 5;

  function automatic logic op_shifts_data(cmd_op_e op);
    return (op == CMD_SCAN) || (op == CMD_SCAN_FLIP_TMS);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK half-period timer.
//  clk, rst   : system clock, synchronous active-high reset
//  run        : sequencer is inside a bit slot (SETUP or HIGH)
//  tck_level  : current tck value, selects which strobe fires
//  rise_o     : pulse on the last cycle of a low half-period
//  fall_o     : pulse on the last cycle of a high half-period
// The counter sits at its reload value whenever run is low, so every
// slot starts with a full TCK_HALF-cycle low phase.
module jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic tck_level,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TCK_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  always_comb begin
    tick  = run && (cnt_q == '0);
    cnt_d = cnt_q - 1'b1;
    if (!run || tick) cnt_d = RELOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

  assign rise_o = tick && !tck_level;
  assign fall_o = tick &&  tck_level;

endmodule

// File: rtl/jtag_vpi_sequencer.sv
// Cycle-driven JTAG bit-bang master.
//  wb_clk_i/wb_rst_i     : clock, synchronous active-high reset
//  enable/init_done      : arming; engine arms on the first enable&&init_done
//  cmd_valid/ready/op/len/data : command channel
//  resp_valid/resp_data  : one-cycle completion pulse with captured tdo bits
//  busy                  : command in progress
//  tck/tms/tdi/tdo       : JTAG pins
//  dbg_state             : current sequencer state (seq_state_e)
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready only depends on internal state and enable, never on cmd_valid.
// resp_valid is a single-cycle pulse with no backpressure.
module jtag_vpi_sequencer
  import jtag_vpi_pkg::*;
#(
  parameter int TCK_HALF = 2,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 6
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable,
  input  logic              init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic [1:0]        dbg_state
);

  seq_state_e        state_q, state_d;
  logic              armed_q, armed_d;
  cmd_op_e           op_q, op_d;
  logic [LEN_W-1:0]  slots_q, slots_d;
  logic [LEN_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;

  logic              rise, fall, accept, last_bit;
  cmd_op_e           acc_op;
  logic [LEN_W-1:0]  acc_slots;

  // tms for slot b of a command
  function automatic logic slot_tms(cmd_op_e op, logic [DATA_W-1:0] data,
                                    logic [LEN_W-1:0] b, logic [LEN_W-1:0] slots);
    logic [DATA_W-1:0] sh;
    sh = data >> b;
    case (op)
      CMD_RESET:         return 1'b1;
      CMD_TMS_SEQ:       return sh[0];
      CMD_SCAN_FLIP_TMS: return (b == slots - 1'b1);
      default:           return 1'b0;
    endcase
  endfunction

  // tdi for slot b of a command
  function automatic logic slot_tdi(cmd_op_e op, logic [DATA_W-1:0] data,
                                    logic [LEN_W-1:0] b);
    logic [DATA_W-1:0] sh;
    sh = data >> b;
    return op_shifts_data(op) ? sh[0] : 1'b0;
  endfunction

  jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .run       ((state_q == ST_SETUP) || (state_q == ST_HIGH)),
    .tck_level (tck_q),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  assign cmd_ready = armed_q && enable && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign acc_op    = cmd_op_e'(cmd_op);
  // RESET ignores len; other ops saturate len at DATA_W
  assign acc_slots = (acc_op == CMD_RESET) ? LEN_W'(RESET_TMS_CYCLES) :
                     (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
  assign last_bit  = (bit_q + 1'b1) == slots_q;

  // State register and datapath flops
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      op_q    <= CMD_RESET;
      slots_q <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      resp_q  <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      op_q    <= op_d;
      slots_q <= slots_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (acc_slots == '0) ? ST_DONE : ST_SETUP;
      ST_SETUP: if (rise)   state_d = ST_HIGH;
      ST_HIGH:  if (fall)   state_d = last_bit ? ST_DONE : ST_SETUP;
      ST_DONE:              state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    armed_d = armed_q || (enable && init_done);
    op_d    = op_q;
    slots_d = slots_q;
    bit_d   = bit_q;
    data_d  = data_q;
    resp_d  = resp_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = acc_op;
          slots_d = acc_slots;
          bit_d   = '0;
          data_d  = cmd_data;
          resp_d  = '0;
          // len=0 issues no slot, so the pins keep their previous values
          if (acc_slots != '0) begin
            tms_d = slot_tms(acc_op, cmd_data, '0, acc_slots);
            tdi_d = slot_tdi(acc_op, cmd_data, '0);
          end
        end
      end
      ST_SETUP: begin
        if (rise) begin
          tck_d = 1'b1;
          if (op_shifts_data(op_q)) resp_d = resp_q | (DATA_W'(tdo) << bit_q);
        end
      end
      ST_HIGH: begin
        if (fall) begin
          tck_d = 1'b0;
          bit_d = bit_q + 1'b1;
          if (!last_bit) begin
            tms_d = slot_tms(op_q, data_q, bit_q + 1'b1, slots_q);
            tdi_d = slot_tdi(op_q, data_q, bit_q + 1'b1);
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    resp_valid = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    resp_data  = resp_q;
    tck        = tck_q;
    tms        = tms_q;
    tdi        = tdi_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_jtag_vpi_sequencer.sv
// Directed + randomized bench for jtag_vpi_sequencer.
module tb_jtag_vpi_sequencer;

  localparam int TCK_HALF = 2;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              enable = 1'b0, init_done = 1'b0, cmd_valid = 1'b0;
  logic [1:0]        cmd_op = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_ready, resp_valid, busy, tck, tms, tdi, tdo;
  logic [DATA_W-1:0] resp_data;
  logic [1:0]        dbg_state;

  // tdo target model: 0 loopback, 1 tied high, 2 inverted loopback
  int tdo_mode = 0;
  assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1) ? 1'b1 : ~tdi;

  jtag_vpi_sequencer #(.TCK_HALF(TCK_HALF), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .enable     (enable),
    .init_done  (init_done),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .dbg_state  (dbg_state)
  );

  // pin monitor: tms/tdi as seen by the target on each tck rise
  logic obs_tms_q[$];
  logic obs_tdi_q[$];
  always @(posedge tck) begin
    obs_tms_q.push_back(tms);
    obs_tdi_q.push_back(tdi);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one command and checks it against the reference model.
  // drop_at > 0 drops enable at that cycle after accept.
  task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                         input int drop_at, input string tag);
    int          n, slots, start, w, seen;
    logic [31:0] exp_resp;
    logic [1:0]  exp_q[$];
    logic [1:0]  e;
    logic        t, d, o;

    // reference model: per-slot {tms,tdi} and captured response
    slots    = (op == 2'd0) ? 5 : ((len > DATA_W) ? DATA_W : len);
    exp_resp = '0;
    for (int i = 0; i < slots; i++) begin
      d = 1'(data >> i);
      case (op)
        2'd0:    begin t = 1'b1; d = 1'b0; end
        2'd1:    begin t = d;    d = 1'b0; end
        2'd2:    t = 1'b0;
        default: t = (i == slots - 1);
      endcase
      exp_q.push_back({t, d});
      o = (tdo_mode == 0) ? d : (tdo_mode == 1) ? 1'b1 : ~d;
      if (op >= 2'd2) exp_resp = exp_resp | (32'(o) << i);
    end

    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready_before"}, 64'(cmd_ready), 64'd1);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    start     = obs_tms_q.size();
    @(negedge clk);
    n = 1;
    cmd_valid = 1'b0;
    check({tag, " ready_after_accept"}, 64'(cmd_ready), 64'd0);
    if (slots > 0) check({tag, " busy"}, 64'(busy), 64'd1);

    while (!resp_valid && n < 400) begin
      if (n == drop_at) enable = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(1 + slots * 2 * TCK_HALF));
    check({tag, " resp_data"}, 64'(resp_data), 64'(exp_resp));
    check({tag, " tck_low"}, 64'(tck), 64'd0);
    seen = obs_tms_q.size() - start;
    check({tag, " tck_pulses"}, 64'(seen), 64'(slots));
    for (int k = 0; k < slots && k < seen; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s slot%0d tms/tdi", tag, k),
            64'({obs_tms_q[start+k], obs_tdi_q[start+k]}), 64'(e));
    end

    @(negedge clk);
    check({tag, " resp_pulse_end"}, 64'(resp_valid), 64'd0);
    check({tag, " resp_hold"}, 64'(resp_data), 64'(exp_resp));
    check({tag, " busy_end"}, 64'(busy), 64'd0);

    if (drop_at > 0) begin
      repeat (3) begin
        check({tag, " ready_while_disabled"}, 64'(cmd_ready), 64'd0);
        @(negedge clk);
      end
      enable = 1'b1;
      @(negedge clk);
      check({tag, " ready_reenabled"}, 64'(cmd_ready), 64'd1);
    end
  endtask

  task automatic arm();
    init_done = 1'b1;
    @(negedge clk);
    init_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv_seen;

    // reset and arming
    rst = 1'b1; enable = 1'b1; init_done = 1'b0;
    repeat (4) @(negedge clk);
    check("rst cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst tck", 64'(tck), 64'd0);
    check("rst tms", 64'(tms), 64'd0);
    check("rst tdi", 64'(tdi), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_data", 64'(resp_data), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("unarmed cmd_ready", 64'(cmd_ready), 64'd0);
    arm();
    check("armed cmd_ready", 64'(cmd_ready), 64'd1);

    // directed commands
    tdo_mode = 0;
    run_cmd(2'd0, 9, 32'hDEADBEEF, 0, "reset_cmd");
    run_cmd(2'd1, 4, 32'h6, 0, "tms_seq");
    run_cmd(2'd2, 8, 32'hA5, 0, "scan_a5");
    tdo_mode = 1;
    run_cmd(2'd3, 3, 32'h5, 0, "flip_tms");
    run_cmd(2'd2, 0, 32'hFFFF_FFFF, 0, "len0");
    tdo_mode = 2;
    run_cmd(2'd2, 40, $urandom, 0, "len_sat");
    run_cmd(2'd3, 32, $urandom, 0, "full_flip");
    tdo_mode = 0;
    run_cmd(2'd2, 8, $urandom, 10, "enable_drop");

    // randomized commands
    for (int r = 0; r < 20; r++) begin
      tdo_mode = $urandom_range(0, 2);
      run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 35), $urandom, 0,
              $sformatf("rand%0d", r));
    end

    // reset in the middle of a SCAN len=16 (during slot 3)
    tdo_mode = 0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = LEN_W'(16); cmd_data = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst tck", 64'(tck), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst resp_valid", 64'(resp_valid), 64'd0);
    check("midrst cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    rv_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    check("midrst no_resp", 64'(rv_seen), 64'd0);
    check("midrst unarmed", 64'(cmd_ready), 64'd0);
    arm();
    check("midrst rearmed", 64'(cmd_ready), 64'd1);
    run_cmd(2'd3, 5, $urandom, 0, "after_rearm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
